// File: rtl/intlv_pkg.sv
// Shared types and constants for the turbo interleaver bank scheduler.
// Holds the block sizes, the per-bank state enum and the size-to-last-index helper.
package intlv_pkg;

  localparam int K_SMALL = 1056;
  localparam int K_LARGE = 6144;
  localparam int ADDR_W  = 13;

  typedef enum logic [1:0] {
    BK_EMPTY,
    BK_FILL,
    BK_FULL,
    BK_DRAIN
  } bank_st_e;

  // Last linear index of a block with the given size tag.
  function automatic int blk_last(input logic sz,
                                  input int   ks,
                                  input int   kl);
    return sz ? (kl - 1) : (ks - 1);
  endfunction

endpackage

// File: rtl/intlv_blk_counter.sv
// Linear index counter for one side (write or read) of the bank scheduler.
// Ports: clk, reset_n, i_clear, i_en, i_size -> o_count, o_last (count == K-1).
module intlv_blk_counter
  import intlv_pkg::*;
#(
  parameter int ADDR_W  = intlv_pkg::ADDR_W,
  parameter int K_SMALL = intlv_pkg::K_SMALL,
  parameter int K_LARGE = intlv_pkg::K_LARGE
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_clear,
  input  logic              i_en,
  input  logic              i_size,
  output logic [ADDR_W-1:0] o_count,
  output logic              o_last
);

  logic [ADDR_W-1:0] r_cnt;
  logic [ADDR_W-1:0] w_lim;

  assign w_lim   = ADDR_W'(blk_last(i_size, K_SMALL, K_LARGE));
  assign o_last  = (r_cnt == w_lim);
  assign o_count = r_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= o_last ? '0 : r_cnt + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/intlv_bank_scheduler.sv
// Ping-pong bank scheduler: fills one interleaver RAM bank while draining the other.
// Ports: wr_start/ack, wr_valid/ready, ram_we, wr_addr | rd_valid/ready, rd_bank,
//   rd_addr, rd_blk_size, rd_last, blk_done | bank_full, wr_abort (INTLV_SCHED_ABORT_EN).
module intlv_bank_scheduler
  import intlv_pkg::*;
#(
  parameter int K_SMALL = intlv_pkg::K_SMALL,
  parameter int K_LARGE = intlv_pkg::K_LARGE,
  parameter int ADDR_W  = intlv_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_start,
  input  logic              wr_blk_size,
  output logic              wr_start_ack,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic [1:0]        ram_we,
  output logic [ADDR_W-1:0] wr_addr,
  input  logic              rd_ready,
  output logic              rd_valid,
  output logic              rd_bank,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_blk_size,
  output logic              rd_last,
  output logic              blk_done,
  output logic [1:0]        bank_full,
  input  logic              wr_abort
);

  bank_st_e          r_st [2];
  bank_st_e          w_st_nx [2];
  logic [1:0]        r_tag, w_tag_nx;
  logic              r_wp, r_rp, w_wp_nx, w_rp_nx;
  logic              r_ack, r_wr_ready, r_blk_done;
  logic [ADDR_W-1:0] w_wcnt, w_rcnt;
  logic              w_wlast, w_rlast;
  logic              w_start, w_wr_xfer, w_wr_done, w_abort;
  logic              w_rd_go, w_rd_valid, w_rd_xfer, w_rd_done;

  assign w_start    = wr_start && (r_st[r_wp] == BK_EMPTY);
  assign w_wr_xfer  = wr_valid && r_wr_ready;
  assign w_wr_done  = w_wr_xfer && w_wlast && !w_abort;
  assign w_rd_go    = (r_st[r_rp] == BK_FULL);
  assign w_rd_valid = (r_st[r_rp] == BK_DRAIN);
  assign w_rd_xfer  = w_rd_valid && rd_ready;
  assign w_rd_done  = w_rd_xfer && w_rlast;

`ifdef INTLV_SCHED_ABORT_EN
  assign w_abort = wr_abort && (r_st[r_wp] == BK_FILL);
`else
  logic w_unused_abort;
  assign w_unused_abort = wr_abort;
  assign w_abort        = 1'b0;
`endif

  intlv_blk_counter #(
    .ADDR_W (ADDR_W),
    .K_SMALL(K_SMALL),
    .K_LARGE(K_LARGE)
  ) u_wcnt (
    .clk    (clk),
    .reset_n(reset_n),
    .i_clear(w_start | w_abort),
    .i_en   (w_wr_xfer & ~w_abort),
    .i_size (r_tag[r_wp]),
    .o_count(w_wcnt),
    .o_last (w_wlast)
  );

  intlv_blk_counter #(
    .ADDR_W (ADDR_W),
    .K_SMALL(K_SMALL),
    .K_LARGE(K_LARGE)
  ) u_rcnt (
    .clk    (clk),
    .reset_n(reset_n),
    .i_clear(w_rd_go),
    .i_en   (w_rd_xfer),
    .i_size (r_tag[r_rp]),
    .o_count(w_rcnt),
    .o_last (w_rlast)
  );

  // Write side only touches bank[wp] (EMPTY/FILL), read side only bank[rp]
  // (FULL/DRAIN), so both updates can apply in the same cycle.
  always_comb begin
    w_st_nx  = r_st;
    w_tag_nx = r_tag;
    w_wp_nx  = r_wp;
    w_rp_nx  = r_rp;
    unique case (1'b1)
      w_start: begin
        w_st_nx[r_wp]  = BK_FILL;
        w_tag_nx[r_wp] = wr_blk_size;
      end
      w_abort: w_st_nx[r_wp] = BK_EMPTY;
      w_wr_done: begin
        w_st_nx[r_wp] = BK_FULL;
        w_wp_nx       = ~r_wp;
      end
      default: ;
    endcase
    unique case (1'b1)
      w_rd_go: w_st_nx[r_rp] = BK_DRAIN;
      w_rd_done: begin
        w_st_nx[r_rp] = BK_EMPTY;
        w_rp_nx       = ~r_rp;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_st[0]    <= BK_EMPTY;
      r_st[1]    <= BK_EMPTY;
      r_tag      <= '0;
      r_wp       <= 1'b0;
      r_rp       <= 1'b0;
      r_ack      <= 1'b0;
      r_wr_ready <= 1'b0;
      r_blk_done <= 1'b0;
    end else begin
      r_st[0]    <= w_st_nx[0];
      r_st[1]    <= w_st_nx[1];
      r_tag      <= w_tag_nx;
      r_wp       <= w_wp_nx;
      r_rp       <= w_rp_nx;
      r_ack      <= w_start;
      r_wr_ready <= (w_st_nx[w_wp_nx] == BK_FILL);
      r_blk_done <= w_rd_done;
    end
  end

  assign wr_start_ack = r_ack;
  assign wr_ready     = r_wr_ready;
  assign ram_we       = !w_wr_xfer ? 2'b00 : (r_wp ? 2'b10 : 2'b01);
  assign wr_addr      = w_wcnt;
  assign rd_valid     = w_rd_valid;
  assign rd_bank      = r_rp;
  assign rd_addr      = w_rcnt;
  assign rd_blk_size  = w_rd_valid & r_tag[r_rp];
  assign rd_last      = w_rd_valid & w_rlast;
  assign blk_done     = r_blk_done;
  assign bank_full[0] = (r_st[0] == BK_FULL) || (r_st[0] == BK_DRAIN);
  assign bank_full[1] = (r_st[1] == BK_FULL) || (r_st[1] == BK_DRAIN);

endmodule

// File: tb/tb_intlv_bank_scheduler.sv
// Directed bench for intlv_bank_scheduler: fill/drain, overlap, stall, reset, abort.
// Expected values are hand-derived from block sizes 1056/6144.
module tb_intlv_bank_scheduler;

  localparam int AW = 13;
  localparam int KS = 1056;
  localparam int KL = 6144;

  logic          clk;
  logic          reset_n;
  logic          wr_start, wr_blk_size, wr_start_ack;
  logic          wr_valid, wr_ready;
  logic [1:0]    ram_we;
  logic [AW-1:0] wr_addr;
  logic          rd_ready, rd_valid, rd_bank;
  logic [AW-1:0] rd_addr;
  logic          rd_blk_size, rd_last, blk_done;
  logic [1:0]    bank_full;
  logic          wr_abort;
  logic [36:0]   all_out;

  int n_cmp = 0;
  int n_err = 0;

  intlv_bank_scheduler dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .wr_start    (wr_start),
    .wr_blk_size (wr_blk_size),
    .wr_start_ack(wr_start_ack),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .ram_we      (ram_we),
    .wr_addr     (wr_addr),
    .rd_ready    (rd_ready),
    .rd_valid    (rd_valid),
    .rd_bank     (rd_bank),
    .rd_addr     (rd_addr),
    .rd_blk_size (rd_blk_size),
    .rd_last     (rd_last),
    .blk_done    (blk_done),
    .bank_full   (bank_full),
    .wr_abort    (wr_abort)
  );

  assign all_out = {wr_start_ack, wr_ready, ram_we, wr_addr, rd_valid,
                    rd_bank, rd_addr, rd_blk_size, rd_last, blk_done,
                    bank_full};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tg,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tg, got, exp);
    end
  endtask

  // Entered just after a negedge with wr_ready expected high.
  task automatic write_n(input int n, input logic [1:0] we,
                         input string tg);
    int bad = 0;
    for (int i = 0; i < n; i++) begin
      wr_valid = 1'b1;
      #1;
      if (ram_we !== we || wr_addr !== AW'(i) ||
          (i > 0 && wr_start_ack !== 1'b0))
        bad++;
      @(negedge clk);
      wr_valid = 1'b0;
    end
    #1;
    check({tg, " bad"}, bad, 0);
  endtask

  task automatic start_blk(input logic sz, input string tg);
    logic got = 1'b0;
    wr_start    = 1'b1;
    wr_blk_size = sz;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      #1;
      got = wr_start_ack;
    end
    wr_start = 1'b0;
    check(tg, got, 1);
  endtask

  task automatic drain(input int k, input logic bank, input logic sz,
                       input bit rnd, input string tg);
    int bad = 0;
    int e   = 0;
    int cyc = 0;
    while (e < k && cyc < 4 * k) begin
      rd_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (rd_valid !== 1'b1 || rd_addr !== AW'(e) || rd_bank !== bank ||
          rd_blk_size !== sz || rd_last !== (e == k - 1))
        bad++;
      if (rd_ready) e++;
      @(negedge clk);
      cyc++;
    end
    rd_ready = 1'b0;
    #1;
    check({tg, " bad"}, bad, 0);
    check({tg, " count"}, e, k);
  endtask

  int nack;
  int rb, re, rdn, rbad, rk;

  initial begin
    reset_n     = 1'b0;
    wr_start    = 1'b0;
    wr_blk_size = 1'b0;
    wr_valid    = 1'b0;
    rd_ready    = 1'b0;
    wr_abort    = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("reset outs", all_out, 0);
    reset_n = 1'b1;

    // Single small block into bank 0, random-stall drain.
    @(negedge clk);
    wr_start    = 1'b1;
    wr_blk_size = 1'b0;
    #1;
    check("t1 no early ack", wr_start_ack, 0);
    @(negedge clk);
    #1;
    check("t1 ack", wr_start_ack, 1);
    check("t1 wr_ready", wr_ready, 1);
    wr_start = 1'b0;
    write_n(KS, 2'b01, "t1 fill");
    check("t1 full", bank_full, 2'b01);
    check("t1 rd_valid+1", rd_valid, 0);
    check("t1 wr_ready drop", wr_ready, 0);
    @(negedge clk);
    #1;
    check("t1 rd_valid+2", rd_valid, 1);
    drain(KS, 1'b0, 1'b0, 1'b1, "t1 drain");
    check("t1 rd_valid off", rd_valid, 0);
    check("t1 blk_done", blk_done, 1);
    check("t1 empty", bank_full, 2'b00);
    @(negedge clk);
    #1;
    check("t1 blk_done pulse", blk_done, 0);

    // Reset mid-fill of bank 1.
    start_blk(1'b1, "t4 ack");
    write_n(500, 2'b10, "t4 fill");
    wr_valid = 1'b1;
    #1;
    check("t4 wcnt500", wr_addr, 500);
    reset_n = 1'b0;
    #1;
    check("t4 async reset", all_out, 0);
    @(negedge clk);
    @(negedge clk);
    reset_n  = 1'b1;
    wr_valid = 1'b0;
    #1;

    // Large block into bank 0, then small into bank 1 overlapping drain.
    start_blk(1'b1, "t2 ackA");
    write_n(KL, 2'b01, "t2 fillA");
    rd_ready = 1'b1;
    rb = 0; re = 0; rdn = 0; rbad = 0;
    fork
      begin
        start_blk(1'b0, "t2 ackB");
        check("t2 overlap", {rd_valid, rd_bank}, 2'b10);
        write_n(KS, 2'b10, "t2 fillB");
      end
      begin
        repeat (7400) begin
          @(negedge clk);
          #1;
          if (blk_done) rdn++;
          if (rd_valid) begin
            rk = (rb == 0) ? KL : KS;
            if (rb > 1 || rd_addr !== AW'(re) || rd_bank !== rb[0] ||
                rd_blk_size !== (rb == 0))
              rbad++;
            re++;
            if (re == rk) begin
              rb++;
              re = 0;
            end
          end
        end
      end
    join
    rd_ready = 1'b0;
    check("t2 read bad", rbad, 0);
    check("t2 blocks", rb, 2);
    check("t2 blk_done cnt", rdn, 2);

    // Both banks full, start held until bank 0 frees.
    start_blk(1'b0, "t3 ack0");
    write_n(KS, 2'b01, "t3 fill0");
    start_blk(1'b0, "t3 ack1");
    write_n(KS, 2'b10, "t3 fill1");
    wr_start    = 1'b1;
    wr_blk_size = 1'b0;
    nack        = 0;
    repeat (10) begin
      @(negedge clk);
      #1;
      nack += int'(wr_start_ack);
    end
    check("t3 no ack full", nack, 0);
    check("t3 both full", bank_full, 2'b11);
    drain(KS, 1'b0, 1'b0, 1'b0, "t3 drain0");
    check("t3 ack not yet", wr_start_ack, 0);
    check("t3 bank0 freed", bank_full, 2'b10);
    @(negedge clk);
    #1;
    check("t3 ack", wr_start_ack, 1);
    check("t3 wr_ready", wr_ready, 1);
    wr_start = 1'b0;

`ifdef INTLV_SCHED_ABORT_EN
    write_n(300, 2'b01, "t5 fill");
    wr_abort = 1'b1;
    wr_valid = 1'b1;
    #1;
    check("t5 wcnt300", wr_addr, 300);
    @(negedge clk);
    wr_abort = 1'b0;
    wr_valid = 1'b0;
    #1;
    check("t5 ready drop", wr_ready, 0);
    check("t5 bank0 empty", bank_full[0], 0);
    start_blk(1'b1, "t5 reack");
    write_n(4, 2'b01, "t5 refill");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/intlv_bank_scheduler.md
Name: intlv_bank_scheduler

Overview:
- Ping-pong bank scheduler for the turbo interleaver's two block RAMs.
- Assigns each bank to the CRC-side writer (linear fill) or the interleaver read side (drain), and tracks each bank's state and block size.
- Generates write enables, linear write/read indices and end-of-block flags so fill of one bank overlaps drain of the other.
- Sits between the CRC output and the interleaver address/permutation datapath; it replaces hard-wired counter sequencing.

Parameters:
- K_SMALL, 1056, block length when blk_size=0.
- K_LARGE, 6144, block length when blk_size=1.
- ADDR_W, 13, index width; must satisfy 2^ADDR_W > K_LARGE.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- wr_start  in  1  request to open a new block; held high until wr_start_ack.
- wr_blk_size  in  1  block size of the request; sampled with wr_start.
- wr_start_ack  out  1  one-cycle pulse; start accepted.
- wr_valid  in  1  input bit/word present.
- wr_ready  out  1  the writer bank is accepting.
- ram_we  out  2  one-hot write enable, bit i = bank i.
- wr_addr  out  ADDR_W  linear write index.
- rd_ready  in  1  downstream accepts the read index.
- rd_valid  out  1  read index valid.
- rd_bank  out  1  bank being drained.
- rd_addr  out  ADDR_W  linear read index; permutation is applied downstream.
- rd_blk_size  out  1  size tag of the bank being drained.
- rd_last  out  1  rd_addr is K-1.
- blk_done  out  1  one-cycle pulse after the last read transfer.
- bank_full  out  2  bit i = bank i is FULL or DRAIN.
- wr_abort  in  1  abort the partial fill; only acted on with the optional feature.

Behaviour:
Reset:
- reset_n low forces both banks to EMPTY, wp=rp=0, counters=0.
- All outputs are 0 during reset, asynchronously, including mid-block. No memory of a partial block survives reset.

Per-bank state: EMPTY -> FILL -> FULL -> DRAIN -> EMPTY. K is K_LARGE if the bank's size tag is 1, else K_SMALL.

Write side:
- Start: if wr_start=1 and bank[wp]==EMPTY, then on the next edge bank[wp]=FILL, the size tag latches wr_blk_size, wcnt=0, and wr_start_ack=1 for that cycle.
- wr_start is evaluated against registered state. A bank freed this cycle is accepted on the following cycle.
- wr_ready=1 iff bank[wp]==FILL; this output is registered.
- Transfer: wr_valid&&wr_ready gives ram_we[wp]=1 and wr_addr=wcnt (combinational from registered wcnt), then wcnt++.
- Transfer at wcnt==K-1: bank[wp]=FULL, wp toggles, wcnt=0, and wr_ready drops the next cycle.
- wr_start during FILL is ignored (no ack).

Read side:
- Bank[rp]==FULL moves to DRAIN on the next edge, with rcnt=0. rd_valid=1 from that cycle. FULL→rd_valid latency is 1 cycle.
- rd_addr=rcnt, rd_bank=rp, rd_blk_size=tag[rp]. rd_last=(rcnt==K-1).
- Transfer: rd_valid&&rd_ready increments rcnt. Outputs hold stable while rd_ready=0.
- Last transfer: bank[rp]=EMPTY, rp toggles, rd_valid=0 the next cycle, and blk_done pulses the next cycle.
- Minimum one idle rd_valid cycle between blocks.

Simultaneous events:
- Write completion on one bank and drain completion on the other in the same cycle are independent and both update.
- A bank never both fills and drains.
- Counters never exceed K-1. Indices wrap to 0 only via block completion.
- Mixed sizes are allowed: each bank uses its own tag.

Optional Feature:
- INTLV_SCHED_ABORT_EN defined: wr_abort=1 while bank[wp]==FILL resets that bank to EMPTY and wcnt=0. wp is unchanged and wr_ready drops the next cycle. Abort has no effect on FULL/DRAIN banks. Abort wins over a simultaneous final write.
- INTLV_SCHED_ABORT_EN not defined: wr_abort is ignored and no abort logic is instantiated.

Decomposition:
- Shared package intlv_pkg: K_SMALL/K_LARGE constants, the bank state enum (EMPTY, FILL, FULL, DRAIN), and a size→K function.
- One sub-module, intlv_blk_counter, instantiated twice (write, read). Interface: clear, enable, size tag, count, is_last.
- Bank state, pointers and handshakes live in the top.

Test Plan:
- Reset, then wr_start=1 with wr_blk_size=0:
  - wr_start_ack pulses 1 cycle later and wr_ready=1.
  - 1056 continuous writes give ram_we=01 and wr_addr 0..1055.
  - bank_full=01 and rd_valid rises 2 cycles after the last write.
- Back-to-back blocks (K_LARGE, then K_SMALL), rd_ready=1:
  - Block 2 fills bank 1 while bank 0 drains.
  - rd_blk_size follows each tag; blk_done pulses exactly twice.
- Both banks FULL and wr_start held:
  - No ack until the bank 0 drain completes.
  - Ack comes exactly 1 cycle after the bank-0→EMPTY transition.
- rd_ready toggled 1/0 randomly through drain: rd_addr is held while stalled, there is no skip or duplicate 0..K-1, and rd_last occurs only at 1055.
- reset_n pulsed low mid-fill (wcnt=500): all outputs 0 immediately; after release, the next wr_start is acked into bank 0 with wr_addr restarting at 0.
- With INTLV_SCHED_ABORT_EN, wr_abort at wcnt=300: bank 0 returns to EMPTY, and the next block refills bank 0 from index 0.
